// File: rtl/host_rsp_serializer.sv
// Serializes an encoded host response as: length byte, payload bytes 0..len-1,
// and an optional trailing XOR checksum, over a valid/ready byte stream.
module host_rsp_serializer #(
   parameter int MAX_BYTES = 128,
   parameter bit CSUM_EN   = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1023:0] frame_data,
   input  logic [7:0]    frame_len,
   input  logic          frame_valid,
   output logic          frame_ready,
   output logic [7:0]    tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   output logic          busy,
   output logic          done,
   output logic          error
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] LEN  = 3'd1;
   localparam logic [2:0] DATA = 3'd2;
   localparam logic [2:0] CSUM = 3'd3;
   localparam logic [2:0] FIN  = 3'd4;

   localparam logic [8:0] MAX_LEN = 9'(MAX_BYTES);

   logic [2:0]    state_q, state_d;
   logic [1023:0] data_q, data_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    idx_q, idx_d;
   logic [7:0]    csum_q, csum_d;
   logic          error_q, error_d;

   logic          accept;
   logic          xfer;
   logic          lenBad;
   logic          lastByte;
   logic [7:0]    payloadByte;

   // Only IDLE takes frames; held low during reset so nothing is offered a handshake.
   assign frame_ready = (state_q == IDLE) & reset;
   assign tx_valid    = (state_q == LEN) | (state_q == DATA) | (state_q == CSUM);
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FIN);
   assign error       = error_q;

   assign accept   = frame_valid & frame_ready;
   assign xfer     = tx_valid & tx_ready;
   assign lenBad   = (frame_len == 8'd0) || ({1'b0, frame_len} > MAX_LEN);
   assign lastByte = (idx_q == (len_q - 8'd1));

   // Index never exceeds 127, so the low seven bits address all 128 payload bytes.
   assign payloadByte = data_q[{idx_q[6:0], 3'b000} +: 8];

   always_comb begin
      tx_data = 8'h00;
      case (state_q)
         LEN:     tx_data = len_q;
         DATA:    tx_data = payloadByte;
         CSUM:    tx_data = csum_q;
         default: tx_data = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      len_d   = len_q;
      idx_d   = idx_q;
      csum_d  = csum_q;
      error_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               data_d = frame_data;
               len_d  = frame_len;
               idx_d  = 8'd0;
               csum_d = 8'd0;
               if (lenBad) begin
                  error_d = 1'b1;
               end else begin
                  state_d = LEN;
               end
            end
         end
         LEN: begin
            if (xfer) begin
               csum_d  = csum_q ^ tx_data;
               state_d = DATA;
            end
         end
         DATA: begin
            if (xfer) begin
               csum_d = csum_q ^ tx_data;
               idx_d  = idx_q + 8'd1;
               if (lastByte) begin
                  state_d = CSUM_EN ? CSUM : FIN;
               end
            end
         end
         CSUM: begin
            if (xfer) begin
               state_d = FIN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         len_q   <= 8'd0;
         idx_q   <= 8'd0;
         csum_q  <= 8'd0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         csum_q  <= csum_d;
         error_q <= error_d;
      end
   end

endmodule

// File: doc/host_rsp_serializer.md
HOST_RSP_SERIALIZER -- requirements
Module: host_rsp_serializer

Interface
- REQ-001 SHALL have parameter MAX_BYTES, default 128, the maximum payload bytes per frame.
- REQ-002 SHALL have parameter CSUM_EN, default 1; when 1, a trailing XOR checksum byte is sent.
- REQ-003 SHALL have port clk  input  1  the single clock; all logic is on posedge.
- REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
- REQ-005 SHALL have port frame_data  input  1024  encoded response; byte k is bits [8k+7:8k].
- REQ-006 SHALL have port frame_len  input  8  payload byte count.
- REQ-007 SHALL have port frame_valid  input  1  frame offered.
- REQ-008 SHALL have port frame_ready  output  1  serializer can accept a frame.
- REQ-009 SHALL have port tx_data  output  8  byte to the UART transmitter.
- REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
- REQ-011 SHALL have port tx_ready  input  1  UART transmitter accepts the byte.
- REQ-012 SHALL have port busy  output  1  a frame is in progress.
- REQ-013 SHALL have port done  output  1  one-cycle pulse when the last byte is accepted.
- REQ-014 SHALL have port error  output  1  one-cycle pulse when a frame length is rejected.

Function
- REQ-015 SHALL implement states IDLE, LEN, DATA, CSUM and FIN.
- REQ-016 In IDLE, frame_ready SHALL be 1 and frame_ready SHALL be 0 in every other state.
- REQ-017 A frame SHALL be accepted on a clock edge where frame_valid=1 and frame_ready=1; frame_data and frame_len are registered on that edge.
- REQ-018 If the accepted frame_len is 0 or greater than MAX_BYTES, the block SHALL pulse error=1 for exactly the next cycle, remain in IDLE and emit no bytes.
- REQ-019 If the accepted length is valid, the block SHALL enter LEN on the next cycle with tx_valid=1 and tx_data=frame_len.
- REQ-020 A byte SHALL transfer on any edge where tx_valid=1 and tx_ready=1.
- REQ-021 While tx_valid=1 and tx_ready=0, tx_data SHALL be held stable.
- REQ-022 Once asserted, tx_valid SHALL NOT drop until the byte transfers.
- REQ-023 LEN SHALL go to DATA on transfer; DATA SHALL send bytes 0 through len-1 in ascending order, one per transfer.
- REQ-024 The byte index SHALL be an 8-bit counter that clears on frame accept and increments on each DATA transfer.
- REQ-025 After the byte at index len-1 transfers, the block SHALL go to CSUM if CSUM_EN=1, else to FIN.
- REQ-026 The CSUM byte SHALL equal the XOR of the length byte and all payload bytes, accumulated as bytes transfer.
- REQ-027 CSUM SHALL go to FIN on transfer.
- REQ-028 FIN SHALL last one cycle with done=1, tx_valid=0 and frame_ready=0, then return to IDLE.
- REQ-029 A new frame SHALL be accepted no earlier than the cycle after FIN.
- REQ-030 tx_valid SHALL be 1 only in LEN, DATA and CSUM.
- REQ-031 Back-to-back tx_ready=1 SHALL yield one byte per cycle with no bubbles between LEN, DATA and CSUM.
- REQ-032 busy SHALL be 1 in LEN, DATA, CSUM and FIN, and 0 in IDLE.
- REQ-033 frame_valid, frame_data and frame_len SHALL be ignored outside IDLE.
- REQ-034 done and error SHALL never be asserted in the same cycle.

Reset
- REQ-035 On reset=0, asynchronously and regardless of state, the block SHALL set: state=IDLE, tx_valid=0, tx_data=0, busy=0, done=0, error=0, counter=0, checksum=0 and the captured frame=0.
- REQ-036 frame_ready SHALL be 0 while reset=0 and SHALL be 1 on the first cycle after reset releases.
- REQ-037 Reset asserted mid-frame SHALL abort the frame; no remaining bytes are sent after release.

Verification
- REQ-038 Bench SHALL check the encrypt-enable response: len=8, frame_data[63:0]=64'h0100000000000002, tx_ready=1 -> bytes 08,02,00,00,00,00,00,00,01,0B on consecutive cycles, then done for 1 cycle.
- REQ-039 Bench SHALL check the yaw response: len=12, [7:0]=04, [87:56]=32'h12345678, [95:88]=00 -> bytes 0C,04,00x6,78,56,34,12,00,00 (checksum 00).
- REQ-040 Bench SHALL check backpressure: tx_ready=0 for 3 cycles while byte index 1 is presented -> tx_data and tx_valid held for those 3 cycles, the byte sequence is unchanged and there are no duplicate bytes.
- REQ-041 Bench SHALL check invalid lengths: len=0 and len=129 -> a 1-cycle error pulse each, tx_valid stays 0, frame_ready returns to 1.
- REQ-042 Bench SHALL check the maximum length: len=128 with byte k=k -> 130 transfers, checksum = 0x80 XOR 0x00 (XOR of 0..127 is 0x00) = 0x80.
- REQ-043 Bench SHALL check reset mid-frame: reset=0 during DATA at index 5 -> tx_valid=0 immediately; after release, a fresh len=8 frame serializes correctly from its length byte.
